// File: rtl/product_unit_sequencer_if.sv
// Bundle of the command, product-unit and response buses of product_unit_sequencer.
//  master : sequencer view (accepts commands, drives the product unit, issues responses)
//  slave  : environment view (execution unit, product unit and response consumer)
//  cmd_*  : valid/ready command with op code and AX/DX/source operands
//  pu_*   : product-unit enable, op, A/B/D operands; R1/R2/OF/CF/FIN results
//  rsp_*  : valid/ready response with AX/DX write-back data, write enables, flags and error
interface product_unit_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_ax;
  logic [15:0] cmd_dx;
  logic [15:0] cmd_src;

  logic        pu_ena;
  logic [3:0]  pu_op;
  logic [15:0] pu_a;
  logic [15:0] pu_b;
  logic [15:0] pu_d;
  logic [15:0] pu_r1;
  logic [15:0] pu_r2;
  logic        pu_of;
  logic        pu_cf;
  logic        pu_fin;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_ax;
  logic [15:0] rsp_dx;
  logic        rsp_ax_we;
  logic        rsp_dx_we;
  logic        rsp_cf;
  logic        rsp_of;
  logic [1:0]  rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_ax, cmd_dx, cmd_src,
    input  pu_r1, pu_r2, pu_of, pu_cf, pu_fin,
    input  rsp_ready,
    output cmd_ready,
    output pu_ena, pu_op, pu_a, pu_b, pu_d,
    output rsp_valid, rsp_ax, rsp_dx, rsp_ax_we, rsp_dx_we, rsp_cf, rsp_of, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_ax, cmd_dx, cmd_src,
    output pu_r1, pu_r2, pu_of, pu_cf, pu_fin,
    output rsp_ready,
    input  cmd_ready,
    input  pu_ena, pu_op, pu_a, pu_b, pu_d,
    input  rsp_valid, rsp_ax, rsp_dx, rsp_ax_we, rsp_dx_we, rsp_cf, rsp_of, rsp_err
  );
endinterface

// File: rtl/product_unit_sequencer.sv
// Initiator side of the product-unit interface. Accepts one ALU command at a time, drives the
// product unit, waits one settle cycle (combinational ops) or for pu_fin (DIV/IDIV), and returns
// AX/DX write-back data, write enables, flags and an error code.
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : product_unit_sequencer_if.master (cmd_*, pu_*, rsp_* buses)
// Parameters: TIMEOUT = max WAIT cycles before the timeout error; TO_W = counter width
// (2**TO_W > TIMEOUT).
// Optional macro PSEQ_DIVOVF_EN: trap unsigned DIV quotient overflow before issuing.
module product_unit_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input logic                     clk,
  input logic                     rst_n,
  product_unit_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StWait, StResp} state_e;

  localparam logic [TO_W-1:0] TimeoutCnt = TO_W'(TIMEOUT);
  localparam logic [3:0]      OpCwd      = 4'b1101;
  localparam logic [1:0]      ErrOk      = 2'b00;
  localparam logic [1:0]      ErrDiv     = 2'b01;
  localparam logic [1:0]      ErrTo      = 2'b10;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      op_q;
  logic [15:0]     ax_q, dx_q, src_q;
  logic [15:0]     rax_q, rax_d, rdx_q, rdx_d;
  logic            rax_we_q, rax_we_d, rdx_we_q, rdx_we_d;
  logic            rcf_q, rcf_d, rof_q, rof_d;
  logic [1:0]      rerr_q, rerr_d;

  logic            accept, is_div, div_zero, div_ovf;
  logic [15:0]     wb_ax, wb_dx;
  logic            wb_ax_we, wb_dx_we, wb_cf, wb_of;

  assign accept   = (state_q == StIdle) && bus.cmd_valid;
  assign is_div   = (bus.cmd_op[3:2] == 2'b01);
  assign div_zero = bus.cmd_op[0] ? (bus.cmd_src == 16'h0000) : (bus.cmd_src[7:0] == 8'h00);

`ifdef PSEQ_DIVOVF_EN
  // Unsigned quotient would not fit the destination: trap before the unit ever sees it.
  assign div_ovf = ((bus.cmd_op == 4'b0100) && (bus.cmd_ax[15:8] >= bus.cmd_src[7:0])) ||
                   ((bus.cmd_op == 4'b0101) && (bus.cmd_dx >= bus.cmd_src));
`else
  assign div_ovf = 1'b0;
`endif

  // Write-back mapping of the unit's results for the captured op.
  always_comb begin
    wb_ax    = bus.pu_r1;
    wb_dx    = 16'h0000;
    wb_ax_we = 1'b1;
    wb_dx_we = 1'b0;
    if (!op_q[3] && op_q[0]) begin
      wb_dx    = bus.pu_r2;
      wb_dx_we = 1'b1;
    end else if (op_q == OpCwd) begin
      wb_ax    = 16'h0000;
      wb_ax_we = 1'b0;
      wb_dx    = bus.pu_r1;
      wb_dx_we = 1'b1;
    end
    wb_cf = (op_q[3:2] == 2'b00) && bus.pu_cf;
    wb_of = (op_q[3:2] == 2'b00) && bus.pu_of;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rax_d    = rax_q;
    rdx_d    = rdx_q;
    rax_we_d = rax_we_q;
    rdx_we_d = rdx_we_q;
    rcf_d    = rcf_q;
    rof_d    = rof_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          if (!is_div) begin
            state_d = StSettle;
          end else if (div_zero || div_ovf) begin
            state_d = StResp;
            rerr_d  = ErrDiv;
          end else begin
            state_d = StWait;
            // Counter holds the index of the current WAIT cycle.
            cnt_d   = TO_W'(1);
          end
        end
      end
      StSettle: begin
        state_d  = StResp;
        rax_d    = wb_ax;
        rdx_d    = wb_dx;
        rax_we_d = wb_ax_we;
        rdx_we_d = wb_dx_we;
        rcf_d    = wb_cf;
        rof_d    = wb_of;
        rerr_d   = ErrOk;
      end
      StWait: begin
        // fin has priority over a timeout in the same cycle.
        if (bus.pu_fin) begin
          state_d  = StResp;
          rax_d    = wb_ax;
          rdx_d    = wb_dx;
          rax_we_d = wb_ax_we;
          rdx_we_d = wb_dx_we;
          rcf_d    = wb_cf;
          rof_d    = wb_of;
          rerr_d   = ErrOk;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StResp;
          rerr_d  = ErrTo;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          // Clear the response so the buses read zero between transactions.
          state_d  = StIdle;
          cnt_d    = '0;
          rax_d    = 16'h0000;
          rdx_d    = 16'h0000;
          rax_we_d = 1'b0;
          rdx_we_d = 1'b0;
          rcf_d    = 1'b0;
          rof_d    = 1'b0;
          rerr_d   = ErrOk;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rax_q    <= 16'h0000;
      rdx_q    <= 16'h0000;
      rax_we_q <= 1'b0;
      rdx_we_q <= 1'b0;
      rcf_q    <= 1'b0;
      rof_q    <= 1'b0;
      rerr_q   <= ErrOk;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rax_q    <= rax_d;
      rdx_q    <= rdx_d;
      rax_we_q <= rax_we_d;
      rdx_we_q <= rdx_we_d;
      rcf_q    <= rcf_d;
      rof_q    <= rof_d;
      rerr_q   <= rerr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 4'h0;
      ax_q  <= 16'h0000;
      dx_q  <= 16'h0000;
      src_q <= 16'h0000;
    end else if (accept) begin
      op_q  <= bus.cmd_op;
      ax_q  <= bus.cmd_ax;
      dx_q  <= bus.cmd_dx;
      src_q <= bus.cmd_src;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.pu_ena    = (state_q == StWait);
  assign bus.pu_op     = (state_q != StIdle) ? op_q  : 4'h0;
  assign bus.pu_a      = (state_q != StIdle) ? ax_q  : 16'h0000;
  assign bus.pu_b      = (state_q != StIdle) ? src_q : 16'h0000;
  assign bus.pu_d      = (state_q != StIdle) ? dx_q  : 16'h0000;

  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_ax    = rax_q;
  assign bus.rsp_dx    = rdx_q;
  assign bus.rsp_ax_we = rax_we_q;
  assign bus.rsp_dx_we = rdx_we_q;
  assign bus.rsp_cf    = rcf_q;
  assign bus.rsp_of    = rof_q;
  assign bus.rsp_err   = rerr_q;

endmodule
